// File: rtl/trace_pkg.sv
// Shared encodings for the retired-instruction trace buffer: capture modes,
// FSM states, record field layout and commit flag bit positions.
package trace_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_WRAP = 2'd1,
    MODE_FILL = 2'd2,
    MODE_TRIG = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_FROZEN  = 2'd3
  } state_e;

  localparam int INSTR_W = 32;
  localparam int FLAGS_W = 3;

  // Bit positions inside the 3-bit {MemWrite, RegWrite, PCSrc} flag field
  localparam int FLAG_PCSRC    = 0;
  localparam int FLAG_REGWRITE = 1;
  localparam int FLAG_MEMWRITE = 2;

  // Record layout, LSB first: flags, alu, instr, pc
  localparam int FLAGS_LSB = 0;
  localparam int ALU_LSB   = FLAGS_W;

  function automatic int instr_lsb(input int xlen);
    return ALU_LSB + xlen;
  endfunction

  function automatic int pc_lsb(input int xlen);
    return ALU_LSB + xlen + INSTR_W;
  endfunction

  function automatic int rec_width(input int xlen);
    return 2 * xlen + INSTR_W + FLAGS_W;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace record storage: one synchronous write port and one asynchronous read
// port, so the oldest entry can be presented and popped every cycle.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int REC_W = 99
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [REC_W-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [REC_W-1:0] rdata
);

  logic [REC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/trace_buffer.sv
// Retired-instruction trace buffer: captures commit records in WRAP, FILL or
// PC-triggered mode, then freezes and drains oldest-first over valid/ready.
module trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int REC_W = rec_width(XLEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_valid,
  input  logic [XLEN-1:0]  commit_pc,
  input  logic [31:0]      commit_instr,
  input  logic [XLEN-1:0]  commit_alu,
  input  logic [2:0]       commit_flags,
  input  logic [1:0]       cfg_mode,
  input  logic [XLEN-1:0]  cfg_trig_pc,
  input  logic [PTR_W:0]   cfg_post,
  input  logic             arm,
  input  logic             stop,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [REC_W-1:0] rd_data,
  output logic [PTR_W:0]   count,
  output logic [1:0]       state,
  output logic             overflow,
  output logic             triggered
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] LAST_CNT = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

  state_e           cur_state, nxt_state;
  mode_e            mode_q;
  logic [XLEN-1:0]  trig_pc_q;
  logic [PTR_W:0]   post_cfg_q, post_cnt, count_q, post_sat;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             overflow_q, triggered_q;
  logic             do_write, do_pop, trig_hit, full;
  logic [REC_W-1:0] wr_rec, ram_rd;

  assign full     = (count_q == FULL_CNT);
  assign trig_hit = (mode_q == MODE_TRIG) && (commit_pc == trig_pc_q);
  assign post_sat = (cfg_post > LAST_CNT) ? LAST_CNT : cfg_post;
  assign wr_rec   = {commit_pc, commit_instr, commit_alu, commit_flags};
  assign rd_valid = (cur_state == ST_FROZEN) && (count_q != '0);
  assign rd_data  = rd_valid ? ram_rd : '0;

  assign count     = count_q;
  assign state     = cur_state;
  assign overflow  = overflow_q;
  assign triggered = triggered_q;

  trace_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W), .REC_W(REC_W)) u_ram (
    .clk   (clk),
    .we    (do_write),
    .waddr (wr_ptr),
    .wdata (wr_rec),
    .raddr (rd_ptr),
    .rdata (ram_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur_state <= ST_IDLE;
    else      cur_state <= nxt_state;
  end

  // arm overrides everything; stop is applied after the commit rules so the
  // same-cycle commit is still written before freezing
  always_comb begin
    nxt_state = cur_state;
    do_write  = 1'b0;
    do_pop    = 1'b0;
    if (arm) begin
      nxt_state = (cfg_mode == MODE_OFF) ? ST_IDLE : ST_CAPTURE;
    end else begin
      case (cur_state)
        ST_CAPTURE: begin
          do_write = commit_valid;
          if (commit_valid) begin
            if (mode_q == MODE_FILL && count_q == LAST_CNT)
              nxt_state = ST_FROZEN;
            else if (trig_hit)
              nxt_state = (post_cfg_q == '0) ? ST_FROZEN : ST_POST;
          end
          if (stop) nxt_state = ST_FROZEN;
        end
        ST_POST: begin
          do_write = commit_valid;
          if (commit_valid && post_cnt == ONE_CNT) nxt_state = ST_FROZEN;
          if (stop) nxt_state = ST_FROZEN;
        end
        ST_FROZEN: begin
          do_pop = rd_valid && rd_ready;
          if (do_pop && count_q == ONE_CNT) nxt_state = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q      <= MODE_OFF;
      trig_pc_q   <= '0;
      post_cfg_q  <= '0;
      post_cnt    <= '0;
      count_q     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_q  <= 1'b0;
      triggered_q <= 1'b0;
    end else if (arm) begin
      mode_q      <= mode_e'(cfg_mode);
      trig_pc_q   <= cfg_trig_pc;
      post_cfg_q  <= post_sat;
      post_cnt    <= '0;
      count_q     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_q  <= 1'b0;
      triggered_q <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
        // FILL never reaches a full write in capture, so full means overwrite
        if (full) begin
          rd_ptr     <= rd_ptr + 1'b1;
          overflow_q <= 1'b1;
        end else begin
          count_q <= count_q + 1'b1;
        end
        if (cur_state == ST_CAPTURE && trig_hit) begin
          triggered_q <= 1'b1;
          post_cnt    <= post_cfg_q;
        end
        if (cur_state == ST_POST) post_cnt <= post_cnt - 1'b1;
      end
      if (do_pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trace_buffer.sv
// Self-checking bench for trace_buffer: directed scenarios with random record
// data plus a random tail, checked against a queue-based reference model.
module tb_trace_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int PTR_W = 4;
  localparam int REC_W = 2 * XLEN + 35;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             commit_valid = 1'b0;
  logic [XLEN-1:0]  commit_pc = '0;
  logic [31:0]      commit_instr = '0;
  logic [XLEN-1:0]  commit_alu = '0;
  logic [2:0]       commit_flags = '0;
  logic [1:0]       cfg_mode = '0;
  logic [XLEN-1:0]  cfg_trig_pc = '0;
  logic [PTR_W:0]   cfg_post = '0;
  logic             arm = 1'b0;
  logic             stop = 1'b0;
  logic             rd_ready = 1'b0;
  logic             rd_valid;
  logic [REC_W-1:0] rd_data;
  logic [PTR_W:0]   count;
  logic [1:0]       state;
  logic             overflow;
  logic             triggered;

  int compared = 0;
  int mismatched = 0;

  // reference model: captured records as a queue, oldest at index 0
  logic [REC_W-1:0] mq[$];
  int m_state, m_mode, m_post, m_postcfg;
  logic m_ovf, m_trig;
  logic [XLEN-1:0] m_trigpc;
  logic [XLEN-1:0] next_pc;
  logic rand_pc = 1'b0;
  logic [XLEN-1:0] last_pc;

  trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_instr(commit_instr), .commit_alu(commit_alu), .commit_flags(commit_flags),
    .cfg_mode(cfg_mode), .cfg_trig_pc(cfg_trig_pc), .cfg_post(cfg_post),
    .arm(arm), .stop(stop), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .count(count), .state(state), .overflow(overflow),
    .triggered(triggered)
  );

  always #5 clk = ~clk;

  task automatic checkField(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_state = 0;
    m_ovf   = 1'b0;
    m_trig  = 1'b0;
    m_post  = 0;
  endtask

  // next model state from the inputs presented for the coming edge
  task automatic modelStep();
    logic [REC_W-1:0] rec;
    rec = {commit_pc, commit_instr, commit_alu, commit_flags};
    if (arm) begin
      modelReset();
      m_mode    = int'(cfg_mode);
      m_trigpc  = cfg_trig_pc;
      m_postcfg = (int'(cfg_post) > DEPTH - 1) ? DEPTH - 1 : int'(cfg_post);
      m_state   = (m_mode == 0) ? 0 : 1;
    end else if (m_state == 1 || m_state == 2) begin
      if (commit_valid) begin
        if (mq.size() == DEPTH) begin
          void'(mq.pop_front());
          m_ovf = 1'b1;
        end
        mq.push_back(rec);
        if (m_state == 1) begin
          if (m_mode == 2 && mq.size() == DEPTH) m_state = 3;
          else if (m_mode == 3 && commit_pc == m_trigpc) begin
            m_trig  = 1'b1;
            m_post  = m_postcfg;
            m_state = (m_post == 0) ? 3 : 2;
          end
        end else begin
          m_post--;
          if (m_post == 0) m_state = 3;
        end
      end
      if (stop) m_state = 3;
    end else if (m_state == 3) begin
      if (mq.size() != 0 && rd_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_state = 0;
      end
    end
  endtask

  task automatic checkOutput();
    logic exp_valid;
    logic [REC_W-1:0] exp_data;
    exp_valid = (m_state == 3) && (mq.size() != 0);
    exp_data  = exp_valid ? mq[0] : '0;
    checkField("state", 128'(state), 128'(m_state));
    checkField("count", 128'(count), 128'(mq.size()));
    checkField("overflow", 128'(overflow), 128'(m_ovf));
    checkField("triggered", 128'(triggered), 128'(m_trig));
    checkField("rd_valid", 128'(rd_valid), 128'(exp_valid));
    checkField("rd_data", 128'(rd_data), 128'(exp_data));
  endtask

  task automatic applyStimulus(input logic a, input logic s, input logic cv, input logic rdy);
    arm          = a;
    stop         = s;
    commit_valid = cv;
    rd_ready     = rdy;
    commit_pc    = rand_pc ? XLEN'($urandom_range(0, 15) * 4) : next_pc;
    commit_instr = $urandom;
    commit_alu   = $urandom;
    commit_flags = 3'($urandom);
    modelStep();
    if (cv) next_pc = next_pc + 4;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic armMode(input int mode, input logic [XLEN-1:0] tpc, input int post);
    cfg_mode    = 2'(mode);
    cfg_trig_pc = tpc;
    cfg_post    = (PTR_W+1)'(post);
    next_pc     = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // pattern 0: always ready, 1: toggle 1,0,1..., 2: random
  task automatic drain(input int pattern);
    logic rdy;
    for (int i = 0; i < 80 && state != 2'd0; i++) begin
      rdy = (pattern == 0) ? 1'b1 : (pattern == 1) ? (i % 2 == 0) : 1'($urandom);
      if (rd_valid && rdy) last_pc = rd_data[REC_W-1 -: XLEN];
      applyStimulus(1'b0, 1'b0, 1'b0, rdy);
    end
    checkField("drain_idle", 128'(state), 128'(0));
  endtask

  initial begin
    modelReset();
    m_mode = 0;
    next_pc = '0;
    @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b1;

    $display("[TB] FILL capture");
    armMode(2, '0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkField("fill_count", 128'(count), 128'(16));
    checkField("fill_state", 128'(state), 128'(3));
    checkField("fill_first_pc", 128'(rd_data[REC_W-1 -: XLEN]), 128'(32'h0));
    drain(0);
    checkField("fill_last_pc", 128'(last_pc), 128'(32'h3C));

    $display("[TB] WRAP capture then stop");
    armMode(1, '0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkField("wrap_overflow", 128'(overflow), 128'(1));
    checkField("wrap_first_pc", 128'(rd_data[REC_W-1 -: XLEN]), 128'(32'h10));
    drain(2);
    checkField("wrap_last_pc", 128'(last_pc), 128'(32'h4C));

    $display("[TB] TRIG capture, post 3, stalled drain");
    armMode(3, 32'h24, 3);
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkField("trig_flag", 128'(triggered), 128'(1));
    checkField("trig_count", 128'(count), 128'(13));
    drain(1);
    checkField("trig_last_pc", 128'(last_pc), 128'(32'h30));

    $display("[TB] TRIG capture, post 0");
    armMode(3, 32'h24, 0);
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    drain(0);
    checkField("trig0_last_pc", 128'(last_pc), 128'(32'h24));

    $display("[TB] TRIG capture, saturated post");
    armMode(3, 32'h08, 31);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0), 1'b0);
    drain(2);

    $display("[TB] arm with commit");
    armMode(1, '0, 0);
    for (int i = 0; i < 18; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkField("rearm_count", 128'(count), 128'(0));
    checkField("rearm_state", 128'(state), 128'(1));
    checkField("rearm_overflow", 128'(overflow), 128'(0));

    $display("[TB] reset during POST");
    armMode(3, 32'h10, 10);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkField("post_state", 128'(state), 128'(2));
    #3;
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput();
    checkField("rst_count", 128'(count), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    checkOutput();

    $display("[TB] random traffic");
    rand_pc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        cfg_mode    = 2'($urandom);
        cfg_trig_pc = XLEN'($urandom_range(0, 15) * 4);
        cfg_post    = (PTR_W+1)'($urandom);
        applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        applyStimulus(1'b0, $urandom_range(0, 29) == 0,
                      $urandom_range(0, 3) != 0, 1'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/trace_buffer.md
# trace_buffer

Synthesizable retired-instruction trace buffer for the single-cycle RISC-V core. It records one entry per retired instruction (PC, instruction word, ALU result, MemWrite/RegWrite/PCSrc flags) into a parametrised circular store. Capture modes are continuous wrap, fill-and-stop, and PC-triggered with post-trigger count. After capture the buffer freezes and is drained oldest-first over a valid/ready port. It sits beside `Single_Cycle_Top`, fed from its commit signals, and replaces simulation-only `$display` logging with on-chip capture.

## Interface
- `XLEN`, 32, datapath width of PC and ALU fields
- `DEPTH`, 16, entry count; power of two, ≥2
- `PTR_W`, $clog2(DEPTH), derived; not overridden
- `REC_W`, 2*XLEN+35, derived record width

- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `commit_valid`  in  1  an instruction retires this cycle
- `commit_pc`  in  XLEN  PC of retiring instruction
- `commit_instr`  in  32  instruction word
- `commit_alu`  in  XLEN  ALU result
- `commit_flags`  in  3  {MemWrite, RegWrite, PCSrc}
- `cfg_mode`  in  2  0 OFF, 1 WRAP, 2 FILL, 3 TRIG; sampled on `arm`
- `cfg_trig_pc`  in  XLEN  trigger PC for TRIG; sampled on `arm`
- `cfg_post`  in  PTR_W+1  entries captured after trigger entry; sampled on `arm`, values > DEPTH-1 saturate to DEPTH-1
- `arm`  in  1  pulse: clear buffer, start capture
- `stop`  in  1  pulse: freeze capture (WRAP/TRIG before trigger)
- `rd_valid`  out  1  oldest entry available
- `rd_ready`  in  1  consumer accepts entry
- `rd_data`  out  REC_W  {pc, instr, alu, flags}; 0 when `rd_valid`=0
- `count`  out  PTR_W+1  stored entries, 0..DEPTH
- `state`  out  2  IDLE=0, CAPTURE=1, POST=2, FROZEN=3
- `overflow`  out  1  sticky: an entry was overwritten
- `triggered`  out  1  sticky: trigger PC matched

## Operation
- IDLE: no writes. `arm` with mode≠OFF → CAPTURE; with OFF → stays IDLE, buffer cleared.
- CAPTURE: each `commit_valid` writes at `wr_ptr`, advances `wr_ptr` (mod DEPTH).
  - Full in WRAP/TRIG: the write overwrites oldest; `rd_ptr` advances, `count` stays DEPTH, `overflow` set.
  - FILL: the write that makes `count`=DEPTH → FROZEN. Commits in FROZEN are ignored.
  - TRIG: commit with `commit_pc`==trigger PC is written, `triggered` set. Then `post_cnt`←cfg_post; if 0 → FROZEN, else → POST.
  - `stop` → FROZEN. The commit in the same cycle is still written.
- POST: each commit written (wrap rules apply), `post_cnt` decrements; the write taking it to 0 → FROZEN. `stop` → FROZEN.
- FROZEN: `rd_valid`=(count≠0); `rd_data`=entry at `rd_ptr`. `rd_valid`&`rd_ready` pops the entry (`rd_ptr`++, `count`--). The pop emptying the buffer → IDLE.
- `arm` in any state has priority over `stop`, commit and pop in the same cycle. It clears pointers, `count`, `overflow`, `triggered`; that cycle's commit is not recorded.
- `rd_valid` is 0 outside FROZEN; `rd_ready` is ignored there.

## Timing
- Reset: `state` IDLE, pointers 0, `count` 0, `overflow` 0, `triggered` 0, `rd_valid` 0, `rd_data` 0.
- Reset mid-capture or mid-drain discards all contents; RAM contents need no reset.
- Write latency 1: commit at edge N is visible in `count` after edge N.
- FROZEN is entered on the same edge as the final write. `rd_valid` is high the following cycle.
- Read is combinational from storage: one pop per cycle at full throughput. `rd_data` is stable while `rd_valid`&!`rd_ready`.
- Trigger compare is combinational on the current commit; no extra latency.

## Structure
- `trace_pkg`: mode encodings, state encodings, record field offsets/widths, flag bit positions.
- Sub-module `trace_ram`: DEPTH×REC_W storage, one synchronous write port, one asynchronous read port.
- Top holds the FSM, pointers, count, post counter and sticky flags.

## Test plan
- FILL, DEPTH=16, 20 commits PC 0x00,0x04,…: FROZEN after 16th; `count`=16; drain yields PC 0x00..0x3C in order, then IDLE.
- WRAP, 20 commits then `stop`: `overflow`=1; drain yields PC 0x10..0x4C; `count` 16→0.
- TRIG, trig PC 0x24, cfg_post=3, PCs 0x00..0x40: `triggered`=1; FROZEN after PC 0x30; last entries drained 0x24,0x28,0x2C,0x30.
- TRIG with cfg_post=0: freezes on the trigger entry itself; last drained PC equals 0x24.
- Drain with `rd_ready` toggling 1,0,1: `rd_data` holds while stalled; no entry lost or duplicated.
- `arm` asserted together with `commit_valid`, and `rst` low mid-POST: `count`=0 afterwards; all sticky flags clear; state CAPTURE and IDLE respectively.
